// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial W-bit adder sequencer.
// A single full-adder slice (two half adders plus an OR) is reused once per
// cycle, LSB first, with a carry flip-flop linking consecutive bit positions.
//
// Handshake: start is sampled only in IDLE; the edge that sees start=1 in
// IDLE captures a/b and enters RUN. busy is high for exactly W cycles (RUN),
// then done is high for exactly one cycle (DONE), then the block returns to
// IDLE. start seen in RUN or DONE is dropped, not queued. sum/cout change only
// on the edge entering DONE and hold their value at all other times.
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    // A one-bit counter is kept even for W=1 so the compare stays well formed.
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   res_sh;
    logic [W-1:0]   res_next;
    logic           carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic           last_bit;

    // Full-adder slice built from two half adders and an OR.
    logic ha0_s;
    logic ha0_c;
    logic ha1_c;
    logic s_i;
    logic c_i;

    assign ha0_s = a_sh[0] ^ b_sh[0];
    assign ha0_c = a_sh[0] & b_sh[0];
    assign s_i   = ha0_s ^ carry_q;
    assign ha1_c = ha0_s & carry_q;
    assign c_i   = ha0_c | ha1_c;

    // Result shifts right with the new bit entering at the MSB; written as a
    // shift/OR so the same expression also covers W=1.
    assign res_next = (res_sh >> 1) | (W'(s_i) << (W - 1));
    assign last_bit = (cnt_q == CNT_W'(W - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and status decode from the registered state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, serial shifting, carry and result update.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_next;
                    carry_q <= c_i;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        sum  <= res_next;
                        cout <= c_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: W=8 directed vectors and handshake corners,
// plus exhaustive W=2 and W=1 instances.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8, b8, sum8;
    logic       busy8, done8, cout8;

    logic       start2;
    logic [1:0] a2, b2, sum2;
    logic       busy2, done2, cout2;

    logic       start1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, cout1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] prev_sum;
    logic       prev_cout;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
        string      name;
    } vec_t;

    vec_t vecs[6];

    serial_add_ctrl #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    serial_add_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One W=8 add: pulse start, watch W+2 cycles, check timing and result.
    task automatic add8(input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] es, input logic ec, input string tag);
        int   nb;
        int   nd;
        int   dpos;
        logic held;
        nb = 0; nd = 0; dpos = -1; held = 1'b1;
        @(negedge clk);
        start8 = 1'b1; a8 = va; b8 = vb;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = ~va; b8 = ~vb;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy8) nb++;
            if (done8) begin nd++; dpos = k; end
            if (k < 8 && (sum8 !== prev_sum || cout8 !== prev_cout)) held = 1'b0;
        end
        check($sformatf("%s busy_len", tag), nb, 8);
        check($sformatf("%s done_cnt", tag), nd, 1);
        check($sformatf("%s done_pos", tag), dpos, 8);
        check($sformatf("%s held_in_run", tag), held, 1);
        check($sformatf("%s sum", tag), sum8, es);
        check($sformatf("%s cout", tag), cout8, ec);
        prev_sum = es; prev_cout = ec;
    endtask

    // One exhaustive step for the W=2 instance and, when run1 is set, W=1.
    task automatic run_small(input logic [1:0] va2, input logic [1:0] vb2,
                             input logic va1, input logic vb1, input logic run1);
        int nb2, nd2, dp2, nb1, nd1, dp1;
        logic [2:0] exp2;
        logic [1:0] exp1;
        nb2 = 0; nd2 = 0; dp2 = -1; nb1 = 0; nd1 = 0; dp1 = -1;
        exp2 = {1'b0, va2} + {1'b0, vb2};
        exp1 = {1'b0, va1} + {1'b0, vb1};
        @(negedge clk);
        start2 = 1'b1; a2 = va2; b2 = vb2;
        start1 = run1; a1 = va1; b1 = vb1;
        @(posedge clk);
        #1;
        start2 = 1'b0; start1 = 1'b0; a2 = ~va2; b2 = ~vb2; a1 = ~va1; b1 = ~vb1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy2) nb2++;
            if (done2) begin nd2++; dp2 = k; end
            if (busy1) nb1++;
            if (done1) begin nd1++; dp1 = k; end
        end
        check($sformatf("w2 %0d+%0d result", va2, vb2), {cout2, sum2}, exp2);
        check($sformatf("w2 %0d+%0d busy_len", va2, vb2), nb2, 2);
        check($sformatf("w2 %0d+%0d done_cnt", va2, vb2), nd2, 1);
        check($sformatf("w2 %0d+%0d done_pos", va2, vb2), dp2, 2);
        if (run1) begin
            check($sformatf("w1 %0d+%0d result", va1, vb1), {cout1, sum1}, exp1);
            check($sformatf("w1 %0d+%0d busy_len", va1, vb1), nb1, 1);
            check($sformatf("w1 %0d+%0d done_cnt", va1, vb1), nd1, 1);
            check($sformatf("w1 %0d+%0d done_pos", va1, vb1), dp1, 1);
        end
    endtask

    initial begin
        int   d1, d2, nd, idle_busy;
        logic [7:0] s1, s2;
        logic c1, c2;

        vecs[0] = '{8'h3C, 8'h0F, 8'h4B, 1'b0, "basic"};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, "ff_01"};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, "ff_ff"};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, "zero"};
        vecs[4] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, "a5_5a"};
        vecs[5] = '{8'h80, 8'h81, 8'h01, 1'b1, "80_81"};

        // Reset with start held high and all-ones operands.
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        start2 = 1'b0; a2 = '0; b2 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", busy8, 0);
        check("rst done", done8, 0);
        check("rst sum", sum8, 8'h00);
        check("rst cout", cout8, 0);
        rst = 1'b0; start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst busy", busy8, 0);
        check("post_rst done", done8, 0);
        check("post_rst sum", sum8, 8'h00);
        prev_sum = 8'h00; prev_cout = 1'b0;

        // Table-driven W=8 adds.
        for (int i = 0; i < 6; i++) begin
            add8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].name);
        end

        // start held high continuously; operands change during RUN.
        d1 = -1; d2 = -1; nd = 0; idle_busy = -1;
        s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        @(posedge clk);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 1) begin a8 = 8'hAA; b8 = 8'h55; end
            if (k == 9) idle_busy = busy8;
            if (done8) begin
                nd++;
                if (d1 < 0) begin d1 = k; s1 = sum8; c1 = cout8; end
                else begin d2 = k; s2 = sum8; c2 = cout8; end
            end
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        check("hold first done_pos", d1, 8);
        check("hold first sum", s1, 8'h46);
        check("hold first cout", c1, 0);
        check("hold busy_after_done", idle_busy, 0);
        check("hold second done_pos", d2, 18);
        check("hold second sum", s2, 8'hFF);
        check("hold second cout", c2, 0);
        check("hold done_cnt", nd, 2);
        prev_sum = 8'hFF; prev_cout = 1'b0;

        // Reset after the fourth RUN edge aborts the add.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy8, 0);
        check("abort done", done8, 0);
        check("abort sum", sum8, 8'h00);
        check("abort cout", cout8, 0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("abort no_done", nd, 0);
        prev_sum = 8'h00; prev_cout = 1'b0;
        add8(8'h80, 8'h80, 8'h00, 1'b1, "after_abort");

        // Exhaustive W=2 and W=1.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            run_small(iv[3:2], iv[1:0], iv[1], iv[0], (i < 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that adds two W-bit operands bit-serially, LSB first.
- Reuses one 1-bit adder slice on every cycle: two half adders plus an OR form the full-adder bit, and a carry flip-flop holds the carry between bits.
- Sits beside the half-adder datapath as the controller that time-shares that single slice across all bit positions.
- Uses a start/busy/done handshake toward the requester.

Parameters:
- W, 8, operand and result width in bits; legal range W >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse or level; sampled only in IDLE.
- a  input  W  operand A; captured on the accepted start edge.
- b  input  W  operand B; captured on the accepted start edge.
- busy  output  1  high while the add is in progress (RUN state).
- done  output  1  one-cycle completion pulse.
- sum  output  W  registered result; updated only at completion.
- cout  output  1  registered carry-out of the MSB; updated only at completion.

Behaviour:
- Reset, synchronous, active-high; at the first rising edge with rst=1:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal operand shift registers, result shift register, carry flip-flop and bit counter all clear to 0.
  - rst has priority over every other input.
- States: IDLE, RUN, DONE. busy is 1 only in RUN; done is 1 only in DONE; both are decoded from registered state.
- IDLE, start=1:
  - Load a into shift register A and b into shift register B.
  - carry<=0, cnt<=0, go to RUN.
  - start=0: remain in IDLE.
- RUN, every edge:
  - Compute s_i = A[0]^B[0]^carry and c_i = (A[0]&B[0]) | (carry&(A[0]^B[0])) through the two-half-adder slice.
  - Shift A and B right by one.
  - Shift the result register right, inserting s_i at bit W-1.
  - carry<=c_i, cnt<=cnt+1.
  - When cnt==W-1 on this edge: load sum with the final result register contents (including this edge's s_i), load cout with c_i, go to DONE.
- DONE: one cycle only; unconditionally return to IDLE on the next edge.
- Timing: start accepted at edge E gives busy=1 for exactly W cycles (after edges E..E+W-1) and done=1 for exactly one cycle (after edge E+W). Back-to-back issue rate is one add per W+2 cycles.
- start while in RUN or DONE is ignored; there is no queueing. Changes on a or b after the capture edge have no effect.
- sum and cout hold their last result through IDLE and through the entire next RUN, and change only at the edge entering DONE.
- Arithmetic: {cout,sum} = a + b modulo 2^(W+1), unsigned, with no overflow flag. The counter width is clog2(W), minimum 1 bit.
- W=1: RUN lasts exactly one cycle.
- rst asserted mid-RUN or in DONE: abort, apply reset values at that edge. No done pulse is produced for the aborted operation.

Test Plan:
1. Reset check: hold rst=1 for 2 cycles with start=1, a=8'hFF, b=8'hFF -> busy=0, done=0, sum=8'h00, cout=0. No state change after rst is released with start=0.
2. Basic add, W=8: a=8'h3C, b=8'h0F, start pulse at edge E -> busy=1 for 8 cycles, done=1 only after edge E+8, sum=8'h4B, cout=0. sum stays 8'h00 during RUN.
3. Carry chains: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1. Then a=8'h00, b=8'h00 -> sum=8'h00, cout=0. Each result holds until the next done pulse.
4. Handshake robustness: keep start=1 continuously with a=8'h12, b=8'h34, and change a/b to 8'hAA/8'h55 during RUN. Expected:
   - First result is sum=8'h46, cout=0.
   - Start asserted in DONE is ignored.
   - Next accepted start is in IDLE, giving a second done exactly W+2 cycles after the first.
5. Reset mid-operation: start a=8'h80, b=8'h80, assert rst for one cycle after the 4th RUN edge -> busy=0, done never pulses, sum=8'h00, cout=0. A fresh start with a=8'h80, b=8'h80 then gives sum=8'h00, cout=1.
6. Exhaustive, W=2 and W=1 instances: all operand pairs, one add at a time -> {cout,sum} equals a+b for every pair (16 pairs for W=2, 4 pairs for W=1). busy length equals W and done width is one cycle on every run.
